// File: rtl/mux_scanner.sv
// Analog mux scanner: walks the enabled slots, samples their lines, then pulses S&H reset.
// Define MUX_SCANNER_CLEAR_EN to zero pulse_in bits of masked-off slots at each complete frame.
module mux_scanner #(
    parameter  int MUX_LINES     = 4,
    parameter  int NUM_LINES     = 2,
    parameter  int SETTLE_CYCLES = 1,
    parameter  int SH_CYCLES     = 1,
    localparam int NUM_INPUTS    = NUM_LINES * MUX_LINES,
    localparam int SW            = (MUX_LINES > 1) ? $clog2(MUX_LINES) : 1,
    localparam int MAXC          = (SETTLE_CYCLES > SH_CYCLES) ? SETTLE_CYCLES : SH_CYCLES,
    localparam int CW            = (MAXC > 1) ? $clog2(MAXC) : 1
) (
    input  logic                      pll_clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [MUX_LINES-1:0]      slot_mask,
    input  logic [NUM_LINES-1:0]      line_in,
    input  logic [NUM_INPUTS-1:0]     pulse_out,
    input  logic [NUM_INPUTS*2-1:0]   active_line,
    output logic [MUX_LINES-1:0]      mux_out,
    output logic                      sh_reset,
    output logic [NUM_INPUTS-1:0]     pulse_in,
    output logic [NUM_LINES-1:0]      line_out,
    output logic [NUM_LINES*2-1:0]    out_line,
    output logic [SW-1:0]             slot_index,
    output logic                      frame_valid
);

    typedef enum logic [1:0] {IDLE, SELECT, SAMPLE, SH} state_t;

    state_t                    state_q, state_d;
    logic [SW-1:0]             slot_q, slot_d;
    logic [MUX_LINES-1:0]      mask_q, mask_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      abort_q, abort_d;
    logic [NUM_INPUTS-1:0]     pi_q, pi_d;
    logic [NUM_LINES-1:0]      lo_q, lo_d;
    logic [NUM_LINES*2-1:0]    ol_q, ol_d;
    logic [SW:0]               first, nxt;
    int                        base;

    // Lowest set bit at or above 'from'; MSB of the result flags a hit.
    function automatic logic [SW:0] find_slot(input logic [MUX_LINES-1:0] m,
                                              input int from);
        logic [SW:0] r;
        r = '0;
        for (int i = MUX_LINES - 1; i >= 0; i--) begin
            if (m[i] && i >= from) r = {1'b1, SW'(i)};
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        pi_d    = pi_q;
        lo_d    = lo_q;
        ol_d    = ol_q;
        first   = find_slot(slot_mask, 0);
        nxt     = find_slot(mask_q, int'(slot_q) + 1);
        base    = int'(slot_q) * NUM_LINES;
        unique case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                cnt_d   = '0;
                if (enable) begin
                    mask_d = slot_mask;
                    if (first[SW]) begin
                        state_d = SELECT;
                        slot_d  = first[SW-1:0];
                    end
                end
            end
            SELECT: begin
                if (!enable) begin
                    state_d = SH;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                pi_d[base +: NUM_LINES] = line_in;
                lo_d  = pulse_out[base +: NUM_LINES];
                ol_d  = active_line[base*2 +: NUM_LINES*2];
                cnt_d = '0;
                if (enable && nxt[SW]) begin
                    state_d = SELECT;
                    slot_d  = nxt[SW-1:0];
                end else begin
                    state_d = SH;
                    abort_d = !enable;
`ifdef MUX_SCANNER_CLEAR_EN
                    // Clear lands on the SH entry edge so it is visible with frame_valid.
                    if (enable) begin
                        for (int s = 0; s < MUX_LINES; s++) begin
                            if (!mask_q[s]) pi_d[s*NUM_LINES +: NUM_LINES] = '0;
                        end
                    end
`endif
                end
            end
            SH: begin
                if (cnt_q == CW'(SH_CYCLES - 1)) begin
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    state_d = IDLE;
                    if (enable) begin
                        mask_d = slot_mask;
                        if (first[SW]) begin
                            state_d = SELECT;
                            slot_d  = first[SW-1:0];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pll_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            slot_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            pi_q    <= '0;
            lo_q    <= '0;
            ol_q    <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            pi_q    <= pi_d;
            lo_q    <= lo_d;
            ol_q    <= ol_d;
        end
    end

    // Decoded from registered state only, so it stays one-hot across transitions.
    always_comb begin
        mux_out = '0;
        if (state_q == SELECT || state_q == SAMPLE) mux_out = MUX_LINES'(1) << slot_q;
    end

    assign sh_reset    = (state_q == SH);
    assign frame_valid = (state_q == SH) && (cnt_q == '0) && !abort_q;
    assign pulse_in    = pi_q;
    assign line_out    = lo_q;
    assign out_line    = ol_q;
    assign slot_index  = slot_q;

endmodule

// File: doc/mux_scanner.md
MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 SHALL have parameter MUX_LINES, default 4: number of analog mux slots scanned per frame.
REQ-002 SHALL have parameter NUM_LINES, default 2: number of physical lines sampled per slot; NUM_INPUTS = NUM_LINES*MUX_LINES.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1 (>=1): cycles a slot stays selected before sampling.
REQ-004 SHALL have parameter SH_CYCLES, default 1 (>=1): width of the sample-and-hold reset pulse at frame end.
REQ-005 pll_clk  input  1  sole clock; all logic on its rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 enable  input  1  run scanning while high.
REQ-008 slot_mask  input  MUX_LINES  1 = slot scanned; latched at frame start.
REQ-009 line_in  input  NUM_LINES  physical line levels for the selected slot.
REQ-010 pulse_out  input  NUM_INPUTS  per-input feedback pulses from the processing core.
REQ-011 active_line  input  NUM_INPUTS*2  per-input 2-bit LED flags.
REQ-012 mux_out  output  MUX_LINES  one-hot slot select, zero when no slot is selected.
REQ-013 sh_reset  output  1  sample-and-hold reset pulse.
REQ-014 pulse_in  output  NUM_INPUTS  demultiplexed samples; bit slot*NUM_LINES+x holds line x of that slot.
REQ-015 line_out  output  NUM_LINES  pulse_out slice of the last sampled slot.
REQ-016 out_line  output  NUM_LINES*2  active_line slice of the last sampled slot.
REQ-017 slot_index  output  clog2(MUX_LINES)  index of the currently selected slot.
REQ-018 frame_valid  output  1  one-cycle strobe when pulse_in holds a complete frame.

Function
REQ-019 SHALL implement states IDLE, SELECT, SAMPLE and SH.
REQ-020 IDLE: mux_out=0 and sh_reset=0. If enable=1, latch slot_mask; if the latched mask is non-zero, go to SELECT on the lowest set slot.
REQ-021 SELECT: mux_out=1<<slot_index. Hold for SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-022 SAMPLE, one cycle, mux_out still asserted: for each x, pulse_in[slot*NUM_LINES+x]<=line_in[x]; line_out[x]<=pulse_out[slot*NUM_LINES+x]; out_line[x*2+:2]<=active_line[(slot*NUM_LINES+x)*2+:2].
REQ-023 After SAMPLE: go to SELECT on the next higher set mask bit; if none remains, go to SH.
REQ-024 SH: mux_out=0, sh_reset=1 for SH_CYCLES cycles; frame_valid=1 on the first SH cycle only.
REQ-025 At SH end: if enable=1, re-latch slot_mask and go to SELECT on its lowest set slot (no IDLE cycle); otherwise go to IDLE.
REQ-026 Frame period SHALL equal popcount(mask)*(SETTLE_CYCLES+1)+SH_CYCLES cycles.
REQ-027 A zero latched mask SHALL hold the block in IDLE; no sh_reset and no frame_valid are produced.
REQ-028 enable falling during SELECT/SAMPLE: finish the current SAMPLE if already in it, skip the remaining slots, go to SH, then IDLE. Suppress frame_valid for that partial frame.
REQ-029 slot_mask changes mid-frame SHALL have no effect until the next latch.
REQ-030 pulse_in bits of masked-off slots SHALL hold their previous value unless MUX_SCANNER_CLEAR_EN is defined.
REQ-031 mux_out SHALL never have more than one bit set, including on state transitions.

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE, clear the settle/SH counters, and zero mux_out, sh_reset, pulse_in, line_out, out_line, slot_index and frame_valid.
REQ-033 Reset asserted mid-frame SHALL discard the frame; after release, scanning restarts from IDLE.

Configuration
REQ-034 With macro MUX_SCANNER_CLEAR_EN defined: on the first SH cycle of a complete frame, pulse_in bits of slots masked off in that frame SHALL be cleared to 0.
REQ-035 Without MUX_SCANNER_CLEAR_EN: masked-off bits SHALL retain their values, and no clear logic is synthesised.

Verification (defaults: MUX_LINES=4, NUM_LINES=2, SETTLE=1, SH=1)
REQ-036 Mask 4'b1111, enable=1 -> mux_out sequence 0001,0001,0010,0010,0100,0100,1000,1000, then 0000 with sh_reset=1 and frame_valid=1; period 9 cycles.
REQ-037 line_in=2'b10 only while slot 2 is selected -> pulse_in=8'b0010_0000 at frame_valid.
REQ-038 Mask 4'b0101 -> slots 0 and 2 only; period 5 cycles. With CLEAR_EN, bits 3:2 and 7:6 are 0 at frame_valid; without it, they are unchanged.
REQ-039 enable dropped during slot 1 SELECT -> no SAMPLE of slot 1; one SH pulse, no frame_valid, then IDLE with mux_out=0.
REQ-040 reset_n pulsed low during slot 3 SAMPLE -> all outputs 0 asynchronously; the next frame after release starts at slot 0.
